spi_regbank: RTL and testbench
==============================

// Module: spi_regbank
// PURPOSE
//  Parametrised SPI register bank: spi_reg serial front end, linear map of NUM_CFG R/W config
//  registers, NUM_STATUS status registers with per-bit sticky/W1C capture, IRQ_EN register and
//  a level interrupt. Independent NUM_CFG/NUM_STATUS, per-register reset values, write strobes.
//  Sits between chip pins (SPI) and user logic config/status buses, all in clk domain.
// PARAMETERS
//  NUM_CFG      8   number of config registers (>=1)
//  NUM_STATUS   8   number of status registers (1..REG_WIDTH)
//  REG_WIDTH    8   register width in bits
//  CFG_RESET    '0  [NUM_CFG*REG_WIDTH-1:0] reset value, reg k in [k*REG_WIDTH +: REG_WIDTH]
//  STICKY_MASK  '0  [NUM_STATUS*REG_WIDTH-1:0] 1 = sticky/W1C bit, 0 = live bit
// PORTS
//  clk          in   1                      clock
//  rstb         in   1                      reset, asynchronous, active-low
//  ena          in   1                      block enable; 0 freezes all register updates
//  mode         in   2                      SPI CPOL/CPHA, passed to spi_reg
//  spi_cs_n     in   1                      SPI chip select, active-low
//  spi_clk      in   1                      SPI clock
//  spi_mosi     in   1                      SPI data in
//  spi_miso     out  1                      SPI data out
//  config_regs  out  NUM_CFG*REG_WIDTH      config registers, reg k at [k*REG_WIDTH +: REG_WIDTH]
//  cfg_wr_stb   out  NUM_CFG                1-clk pulse, bit k when cfg reg k written
//  status_regs  in   NUM_STATUS*REG_WIDTH   raw status from user logic, clk domain
//  irq          out  1                      registered interrupt, active-high level
// BEHAVIOUR
//  Map: ADDR_W = max(1,$clog2(NUM_CFG+NUM_STATUS+1)). 0..NUM_CFG-1 cfg; NUM_CFG..
//   NUM_CFG+NUM_STATUS-1 status; IRQ_EN at NUM_CFG+NUM_STATUS; higher addr read 0, write ignored.
//  Reset: config_regs=CFG_RESET, cfg_wr_stb=0, IRQ_EN=0, sticky=0, raw_q=0, irq=0, spi_miso
//   per spi_reg reset.
//  Write (reg_data_o_dv=1 and ena=1), applied on that clk edge:
//   - cfg addr k: config_regs[k]<=data; cfg_wr_stb[k]=1 next cycle only, even if value unchanged.
//   - status addr s: sticky[s] <= sticky[s] & ~(data & STICKY_MASK[s]); live bits unaffected.
//   - IRQ_EN: bits [NUM_STATUS-1:0] stored, upper bits read 0.
//  Status capture, every clk with ena=1: raw_q<=status_regs; sticky bit b of reg s sets when
//   STICKY_MASK bit=1 and raw_q=0, status_regs=1 (rising edge). Set and W1C same cycle: set wins.
//  Read data (comb. to spi_reg reg_data_i, from reg_addr): cfg -> config_regs[k];
//   status -> (sticky & MASK) | (raw_q & ~MASK); IRQ_EN -> zero-extended enable bits.
//   Live-bit read latency: status_regs to readable = 1 clk.
//  irq <= |over s (IRQ_EN[s] & |sticky[s]); 1 clk after sticky change; live bits never raise irq.
//  ena=0: registers, sticky, raw_q, irq hold; SPI writes dropped; cfg_wr_stb=0; edges lost.
//  CS deassert mid-frame: no write reaches bank (spi_reg emits dv only on a completed frame).
//  Reset mid-frame: async clear of all state above and of spi_reg; next frame decodes cleanly.
//  NUM_STATUS>REG_WIDTH or NUM_CFG<1: elaboration $error.
// STRUCTURE
//  Package spi_regbank_pkg: function regbank_addr_w(ncfg,nstat), IRQ_EN offset localparam helper,
//   status_sel_t struct {is_cfg,is_stat,is_irqen,index} returned by decode function.
//  Sub-module spi_status_cell (one per status register, generate loop): raw_q, edge detect,
//   sticky/W1C, live/sticky read mux, any_sticky output. spi_reg instance unchanged.
// TESTING
//  Reset: CFG_RESET=64'h0706050403020100 -> read addr 0..7 returns 00..07; irq=0; cfg_wr_stb=0.
//  Write addr 3 = 8'hA5 -> config_regs[31:24]=A5, cfg_wr_stb=8'b0000_1000 for exactly 1 clk.
//  STICKY_MASK reg 0 = 8'h0F: pulse status bit 1 for 1 clk -> read addr 8 = 8'h02; hold bit 5
//   high -> read 8'h22; write addr 8 = 8'h02 -> read 8'h20.
//  IRQ_EN=8'h01, sticky set in reg 0 -> irq=1 one clk later; W1C same cycle as new rising
//   edge on same bit -> bit stays 1, irq stays 1; clear without edge -> irq=0 next clk.
//  NUM_CFG=3,NUM_STATUS=2: IRQ_EN at 5; write addr 7 -> no change, read 00; ena=0 write dropped.
//  Assert rstb low mid-frame after writing cfg 0 = 8'h55 -> config_regs[7:0]=CFG_RESET, next
//   full frame write/read-back correct.

Source files
------------

// File: rtl/spi_regbank_pkg.sv
// rtl/spi_regbank_pkg.sv - address-map helpers shared by the SPI register bank
package spi_regbank_pkg;

    localparam int INDEX_W = 16;

    typedef struct packed {
        logic               is_cfg;
        logic               is_stat;
        logic               is_irqen;
        logic [INDEX_W-1:0] index;
    } status_sel_t;

    function automatic int regbank_addr_w(input int ncfg, input int nstat);
        int w;
        w = $clog2(ncfg + nstat + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int irqen_offset(input int ncfg, input int nstat);
        return ncfg + nstat;
    endfunction

    // Addresses beyond IRQ_EN decode to nothing, so they read 0 and ignore writes.
    function automatic status_sel_t regbank_decode(input int addr, input int ncfg, input int nstat);
        status_sel_t sel;
        sel = '0;
        if (addr < ncfg) begin
            sel.is_cfg = 1'b1;
            sel.index  = INDEX_W'(addr);
        end else if (addr < ncfg + nstat) begin
            sel.is_stat = 1'b1;
            sel.index   = INDEX_W'(addr - ncfg);
        end else if (addr == irqen_offset(ncfg, nstat)) begin
            sel.is_irqen = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/spi_reg.sv
// rtl/spi_reg.sv - oversampled SPI slave: {rw, addr, data} MSB-first frames, clk domain
module spi_reg #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [1:0]        mode,
    input  logic              spi_cs_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [DATA_W-1:0] reg_data_o,
    output logic              reg_data_o_dv
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] ADDR_DONE  = CNT_W'(ADDR_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] FRAME_DONE = CNT_W'(FRAME_W);

    logic [1:0]         cs_sync;
    logic [2:0]         sclk_sync;
    logic [1:0]         mosi_sync;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-2:0] rx;
    logic [FRAME_W-1:0] rx_full;
    logic [DATA_W-1:0]  tx;
    logic               selected;
    logic               sclk_rise;
    logic               sclk_fall;
    logic               sample_edge;
    logic               shift_edge;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cs_sync   <= 2'b11;
            sclk_sync <= '0;
            mosi_sync <= '0;
        end else begin
            cs_sync   <= {cs_sync[0], spi_cs_n};
            sclk_sync <= {sclk_sync[1:0], spi_clk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
        end
    end

    assign selected  = ~cs_sync[1];
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    // Sampling happens on the rising edge when CPOL == CPHA, otherwise on the falling edge.
    assign sample_edge = (mode[1] == mode[0]) ? sclk_rise : sclk_fall;
    assign shift_edge  = (mode[1] == mode[0]) ? sclk_fall : sclk_rise;
    assign rx_full     = {rx, mosi_sync[1]};
    assign spi_miso    = tx[DATA_W-1];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            bit_cnt       <= '0;
            rx            <= '0;
            tx            <= '0;
            reg_addr      <= '0;
            reg_data_o    <= '0;
            reg_data_o_dv <= 1'b0;
        end else begin
            reg_data_o_dv <= 1'b0;
            if (!selected) begin
                bit_cnt <= '0;
                tx      <= '0;
            end else begin
                if (sample_edge && bit_cnt != FRAME_DONE) begin
                    rx      <= rx_full[FRAME_W-2:0];
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == ADDR_LAST)
                        reg_addr <= rx_full[ADDR_W-1:0];
                    if (bit_cnt == LAST_BIT && rx_full[FRAME_W-1]) begin
                        reg_data_o    <= rx_full[DATA_W-1:0];
                        reg_data_o_dv <= 1'b1;
                    end
                end
                // First shift edge after the address loads read data; later ones shift it out.
                if (shift_edge)
                    tx <= (bit_cnt == ADDR_DONE) ? reg_data_i : (tx << 1);
            end
        end
    end

endmodule

// File: rtl/spi_regbank_status_cell.sv
// rtl/spi_regbank_status_cell.sv - one status register: edge capture, sticky/W1C bits, read mux
module spi_status_cell #(
    parameter int                   REG_WIDTH = 8,
    parameter logic [REG_WIDTH-1:0] STICKY    = '0
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 ena,
    input  logic [REG_WIDTH-1:0] raw,
    input  logic                 w1c,
    input  logic [REG_WIDTH-1:0] w1c_data,
    output logic [REG_WIDTH-1:0] rdata,
    output logic                 any_sticky
);

    logic [REG_WIDTH-1:0] raw_q;
    logic [REG_WIDTH-1:0] sticky;
    logic [REG_WIDTH-1:0] set_bits;
    logic [REG_WIDTH-1:0] clr_bits;

    assign set_bits = raw & ~raw_q & STICKY;
    assign clr_bits = w1c ? (w1c_data & STICKY) : '0;

    // A new rising edge in the same cycle as a W1C keeps the bit set.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            raw_q  <= '0;
            sticky <= '0;
        end else if (ena) begin
            raw_q  <= raw;
            sticky <= (sticky & ~clr_bits) | set_bits;
        end
    end

    assign rdata      = sticky | (raw_q & ~STICKY);
    assign any_sticky = |sticky;

endmodule

// File: rtl/spi_regbank.sv
// rtl/spi_regbank.sv - SPI-accessed bank of config, sticky/live status and IRQ enable registers
module spi_regbank
    import spi_regbank_pkg::*;
#(
    parameter int                                NUM_CFG     = 8,
    parameter int                                NUM_STATUS  = 8,
    parameter int                                REG_WIDTH   = 8,
    parameter logic [NUM_CFG*REG_WIDTH-1:0]      CFG_RESET   = '0,
    parameter logic [NUM_STATUS*REG_WIDTH-1:0]   STICKY_MASK = '0
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic                            ena,
    input  logic [1:0]                      mode,
    input  logic                            spi_cs_n,
    input  logic                            spi_clk,
    input  logic                            spi_mosi,
    output logic                            spi_miso,
    output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
    output logic [NUM_CFG-1:0]              cfg_wr_stb,
    input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
    output logic                            irq
);

    localparam int ADDR_W = regbank_addr_w(NUM_CFG, NUM_STATUS);

    if (NUM_STATUS > REG_WIDTH || NUM_STATUS < 1 || NUM_CFG < 1) begin : g_param_check
        $error("spi_regbank: NUM_CFG must be >= 1 and NUM_STATUS within 1..REG_WIDTH");
    end

    logic [ADDR_W-1:0]               reg_addr;
    logic [REG_WIDTH-1:0]            reg_rdata;
    logic [REG_WIDTH-1:0]            reg_wdata;
    logic                            spi_wr_dv;
    logic                            wr;
    status_sel_t                     sel;
    logic [NUM_CFG-1:0]              cfg_hit;
    logic [NUM_STATUS*REG_WIDTH-1:0] stat_rdata;
    logic [NUM_STATUS-1:0]           any_sticky;
    logic [NUM_STATUS-1:0]           irq_en;

    spi_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (REG_WIDTH)
    ) u_spi (
        .clk           (clk),
        .rstb          (rstb),
        .mode          (mode),
        .spi_cs_n      (spi_cs_n),
        .spi_clk       (spi_clk),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .reg_addr      (reg_addr),
        .reg_data_i    (reg_rdata),
        .reg_data_o    (reg_wdata),
        .reg_data_o_dv (spi_wr_dv)
    );

    assign sel = regbank_decode(int'(reg_addr), NUM_CFG, NUM_STATUS);
    assign wr  = spi_wr_dv & ena;

    for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg
        logic [REG_WIDTH-1:0] q;
        assign cfg_hit[k] = wr & sel.is_cfg & (sel.index == INDEX_W'(k));
        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb)
                q <= CFG_RESET[k*REG_WIDTH +: REG_WIDTH];
            else if (cfg_hit[k])
                q <= reg_wdata;
        end
        assign config_regs[k*REG_WIDTH +: REG_WIDTH] = q;
    end

    for (genvar s = 0; s < NUM_STATUS; s++) begin : g_stat
        spi_status_cell #(
            .REG_WIDTH (REG_WIDTH),
            .STICKY    (STICKY_MASK[s*REG_WIDTH +: REG_WIDTH])
        ) u_cell (
            .clk        (clk),
            .rstb       (rstb),
            .ena        (ena),
            .raw        (status_regs[s*REG_WIDTH +: REG_WIDTH]),
            .w1c        (wr & sel.is_stat & (sel.index == INDEX_W'(s))),
            .w1c_data   (reg_wdata),
            .rdata      (stat_rdata[s*REG_WIDTH +: REG_WIDTH]),
            .any_sticky (any_sticky[s])
        );
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cfg_wr_stb <= '0;
            irq_en     <= '0;
            irq        <= 1'b0;
        end else begin
            cfg_wr_stb <= cfg_hit;
            if (wr && sel.is_irqen)
                irq_en <= reg_wdata[NUM_STATUS-1:0];
            if (ena)
                irq <= |(irq_en & any_sticky);
        end
    end

    always_comb begin
        reg_rdata = '0;
        for (int k = 0; k < NUM_CFG; k++)
            if (sel.is_cfg && sel.index == INDEX_W'(k))
                reg_rdata = config_regs[k*REG_WIDTH +: REG_WIDTH];
        for (int s = 0; s < NUM_STATUS; s++)
            if (sel.is_stat && sel.index == INDEX_W'(s))
                reg_rdata = stat_rdata[s*REG_WIDTH +: REG_WIDTH];
        if (sel.is_irqen)
            reg_rdata[NUM_STATUS-1:0] = irq_en;
    end

endmodule

// File: tb/tb_spi_regbank.sv
// tb/tb_spi_regbank.sv - self-checking bench for spi_regbank (8/8 bank and 3/2 bank)
module tb_spi_regbank;

    localparam int HALF = 8;
    localparam logic [63:0] RST0 = 64'h0706050403020100;

    typedef struct {
        int         tgt;
        logic [1:0] md;
        logic       rw;
        int         addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] exp;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstb, ena0, ena1, cs0_n, cs1_n, sclk, mosi, miso0, miso1;
    logic [1:0]  mode;
    logic [63:0] cfg0, stat0;
    logic [7:0]  stb0;
    logic        irq0;
    logic [23:0] cfg1;
    logic [2:0]  stb1;
    logic [15:0] stat1;
    logic        irq1;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         vec_id = 0;
    int         stb_cnt0 = 0;
    int         stb_cnt1 = 0;
    logic [7:0] stb_last0 = '0;
    exp_t       sb[$];
    vec_t       tbl[$];

    spi_regbank #(
        .NUM_CFG(8), .NUM_STATUS(8), .REG_WIDTH(8),
        .CFG_RESET(RST0), .STICKY_MASK(64'h0000_0000_0000_000F)
    ) dut0 (
        .clk(clk), .rstb(rstb), .ena(ena0), .mode(mode), .spi_cs_n(cs0_n), .spi_clk(sclk),
        .spi_mosi(mosi), .spi_miso(miso0), .config_regs(cfg0), .cfg_wr_stb(stb0),
        .status_regs(stat0), .irq(irq0)
    );

    spi_regbank #(
        .NUM_CFG(3), .NUM_STATUS(2), .REG_WIDTH(8)
    ) dut1 (
        .clk(clk), .rstb(rstb), .ena(ena1), .mode(mode), .spi_cs_n(cs1_n), .spi_clk(sclk),
        .spi_mosi(mosi), .spi_miso(miso1), .config_regs(cfg1), .cfg_wr_stb(stb1),
        .status_regs(stat1), .irq(irq1)
    );

    always @(negedge clk) begin
        if (stb0 != '0) begin
            stb_cnt0++;
            stb_last0 = stb0;
        end
        if (stb1 != '0) stb_cnt1++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic spi_xfer(input int tgt, input logic rw, input int addr,
                            input logic [7:0] wdata, output logic [7:0] rdata);
        int          aw, nb;
        logic [31:0] fr;
        logic        cpol, cpha;
        aw    = (tgt == 0) ? 5 : 3;
        nb    = 1 + aw + 8;
        fr    = (32'(rw) << (aw + 8)) | (32'(addr) << 8) | 32'(wdata);
        cpol  = mode[1];
        cpha  = mode[0];
        rdata = '0;
        sclk  = cpol;
        repeat (HALF) @(negedge clk);
        if (tgt == 0) cs0_n = 1'b0; else cs1_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = nb - 1; i >= 0; i--) begin
            if (!cpha) begin
                mosi = fr[i];
                repeat (HALF) @(negedge clk);
                sclk  = ~cpol;
                rdata = {rdata[6:0], (tgt == 0) ? miso0 : miso1};
                repeat (HALF) @(negedge clk);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = fr[i];
                repeat (HALF) @(negedge clk);
                sclk  = cpol;
                rdata = {rdata[6:0], (tgt == 0) ? miso0 : miso1};
                repeat (HALF) @(negedge clk);
            end
        end
        repeat (HALF) @(negedge clk);
        cs0_n = 1'b1;
        cs1_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    function automatic vec_t v(input int tgt, input logic [1:0] md, input logic rw,
                               input int addr, input logic [7:0] wd, input logic [7:0] ex);
        vec_t r;
        r.tgt = tgt; r.md = md; r.rw = rw; r.addr = addr; r.wdata = wd; r.exp = ex;
        return r;
    endfunction

    task automatic run_vecs();
        logic [7:0] rd;
        exp_t       e;
        foreach (tbl[i]) begin
            mode = tbl[i].md;
            if (!tbl[i].rw) sb.push_back('{vec_id, tbl[i].exp});
            spi_xfer(tbl[i].tgt, tbl[i].rw, tbl[i].addr, tbl[i].wdata, rd);
            if (!tbl[i].rw) begin
                e = sb.pop_front();
                check($sformatf("vec%0d_dut%0d_addr%0d", e.id, tbl[i].tgt, tbl[i].addr), rd, e.exp);
            end
            vec_id++;
        end
        tbl.delete();
    endtask

    task automatic await_dv0(output logic ok);
        int n = 0;
        while (dut0.spi_wr_dv !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 1000);
        check("dv_within_budget", 64'(ok), 64'd1);
    endtask

    initial begin
        logic [7:0] dummy;
        logic       ok;
        int         c;
        rstb = 1'b0; ena0 = 1'b1; ena1 = 1'b1; mode = 2'b00;
        cs0_n = 1'b1; cs1_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        stat0 = '0; stat1 = 16'h5A81;
        repeat (4) @(negedge clk);
        check("rst_cfg0", cfg0, RST0);
        check("rst_stb0", 64'(stb0), 64'd0);
        check("rst_irq0", 64'(irq0), 64'd0);
        check("rst_miso0", 64'(miso0), 64'd0);
        check("rst_cfg1", 64'(cfg1), 64'd0);
        rstb = 1'b1;
        repeat (4) @(negedge clk);

        // reset contents, each SPI mode
        for (int a = 0; a < 8; a++) tbl.push_back(v(0, 2'(a), 1'b0, a, 8'h00, 8'(a)));
        tbl.push_back(v(0, 2'b00, 1'b0, 16, 8'h00, 8'h00));
        tbl.push_back(v(0, 2'b00, 1'b0, 20, 8'h00, 8'h00));
        run_vecs();

        c = stb_cnt0;
        tbl.push_back(v(0, 2'b00, 1'b1, 3, 8'hA5, 8'h00));
        run_vecs();
        check("cfg3_value", 64'(cfg0[31:24]), 64'hA5);
        check("stb_pulse_count", 64'(stb_cnt0 - c), 64'd1);
        check("stb_pulse_value", 64'(stb_last0), 64'h08);
        tbl.push_back(v(0, 2'b11, 1'b0, 3, 8'h00, 8'hA5));
        tbl.push_back(v(0, 2'b01, 1'b0, 2, 8'h00, 8'h02));
        run_vecs();

        // sticky capture and W1C on status reg 0 (mask 0F)
        @(negedge clk); stat0[1] = 1'b1;
        @(negedge clk); stat0[1] = 1'b0;
        tbl.push_back(v(0, 2'b00, 1'b0, 8, 8'h00, 8'h02));
        run_vecs();
        stat0[5] = 1'b1;
        tbl.push_back(v(0, 2'b00, 1'b0, 8, 8'h00, 8'h22));
        tbl.push_back(v(0, 2'b00, 1'b1, 8, 8'h02, 8'h00));
        tbl.push_back(v(0, 2'b10, 1'b0, 8, 8'h00, 8'h20));
        run_vecs();
        check("irq_disabled", 64'(irq0), 64'd0);

        // interrupt
        tbl.push_back(v(0, 2'b00, 1'b1, 16, 8'h01, 8'h00));
        tbl.push_back(v(0, 2'b00, 1'b0, 16, 8'h00, 8'h01));
        run_vecs();
        @(negedge clk); stat0[2] = 1'b1;
        @(negedge clk); check("irq_not_yet", 64'(irq0), 64'd0); stat0[2] = 1'b0;
        @(negedge clk); check("irq_set", 64'(irq0), 64'd1);
        fork
            spi_xfer(0, 1'b1, 8, 8'h04, dummy);
            begin
                await_dv0(ok);
                if (ok) begin
                    stat0[2] = 1'b1;
                    @(negedge clk);
                    stat0[2] = 1'b0;
                end
            end
        join
        check("irq_set_wins", 64'(irq0), 64'd1);
        tbl.push_back(v(0, 2'b00, 1'b0, 8, 8'h00, 8'h24));
        run_vecs();
        fork
            spi_xfer(0, 1'b1, 8, 8'h04, dummy);
            begin
                await_dv0(ok);
                if (ok) begin
                    check("irq_before_clear", 64'(irq0), 64'd1);
                    @(negedge clk); check("irq_clear_lag", 64'(irq0), 64'd1);
                    @(negedge clk); check("irq_cleared", 64'(irq0), 64'd0);
                end
            end
        join
        tbl.push_back(v(0, 2'b00, 1'b0, 8, 8'h00, 8'h20));
        run_vecs();

        // small bank: map edges, live status, ena freeze
        tbl.push_back(v(1, 2'b00, 1'b0, 3, 8'h00, 8'h81));
        tbl.push_back(v(1, 2'b01, 1'b0, 4, 8'h00, 8'h5A));
        tbl.push_back(v(1, 2'b00, 1'b1, 7, 8'hFF, 8'h00));
        tbl.push_back(v(1, 2'b00, 1'b0, 7, 8'h00, 8'h00));
        tbl.push_back(v(1, 2'b00, 1'b1, 5, 8'hFF, 8'h00));
        tbl.push_back(v(1, 2'b00, 1'b0, 5, 8'h00, 8'h03));
        tbl.push_back(v(1, 2'b00, 1'b1, 1, 8'h3C, 8'h00));
        tbl.push_back(v(1, 2'b00, 1'b0, 1, 8'h00, 8'h3C));
        run_vecs();
        check("dut1_cfg", 64'(cfg1), 64'h003C00);
        check("dut1_live_no_irq", 64'(irq1), 64'd0);
        ena1 = 1'b0;
        stat1 = 16'h0000;
        c = stb_cnt1;
        tbl.push_back(v(1, 2'b00, 1'b1, 1, 8'h99, 8'h00));
        tbl.push_back(v(1, 2'b00, 1'b0, 1, 8'h00, 8'h3C));
        tbl.push_back(v(1, 2'b00, 1'b0, 3, 8'h00, 8'h81));
        run_vecs();
        check("ena0_no_stb", 64'(stb_cnt1 - c), 64'd0);
        check("ena0_cfg_hold", 64'(cfg1), 64'h003C00);
        ena1 = 1'b1;

        // reset in the middle of a frame
        tbl.push_back(v(0, 2'b00, 1'b1, 0, 8'h55, 8'h00));
        tbl.push_back(v(0, 2'b00, 1'b0, 0, 8'h00, 8'h55));
        run_vecs();
        mode = 2'b00; sclk = 1'b0;
        repeat (HALF) @(negedge clk);
        cs0_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mosi = 1'b1;
            repeat (HALF) @(negedge clk); sclk = 1'b1;
            repeat (HALF) @(negedge clk); sclk = 1'b0;
        end
        rstb = 1'b0;
        @(negedge clk);
        check("midframe_rst_cfg0", 64'(cfg0[7:0]), 64'h00);
        check("midframe_rst_all", cfg0, RST0);
        check("midframe_rst_irq", 64'(irq0), 64'd0);
        cs0_n = 1'b1;
        repeat (4) @(negedge clk);
        rstb = 1'b1;
        repeat (4) @(negedge clk);
        tbl.push_back(v(0, 2'b00, 1'b1, 2, 8'h77, 8'h00));
        tbl.push_back(v(0, 2'b00, 1'b0, 2, 8'h00, 8'h77));
        tbl.push_back(v(0, 2'b00, 1'b0, 0, 8'h00, 8'h00));
        tbl.push_back(v(0, 2'b00, 1'b0, 16, 8'h00, 8'h00));
        run_vecs();
        check("post_rst_cfg2", 64'(cfg0[23:16]), 64'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
